z80_mem_bridge: RTL and testbench

Synchronous bridge between the Z80 core's memory bus and the on-chip 1 KiB program/data RAM. Decodes a 1 KiB address window, registers the address and write data into the RAM, pulses the RAM write enable for exactly one cycle, and stretches read cycles with `wait_n` to cover the RAM's registered read. Sits directly upstream of the RAM, which presents registered read data one edge after it samples its address.

---
 rtl/z80_mem_bridge.sv | 136 +++++++++++++
 tb/tb_z80_mem_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/z80_mem_bridge.sv
// Bridge between the Z80 memory bus and the on-chip 1 KiB RAM.
// Registers the RAM address and write data, and stretches reads with wait_n to cover the RAM's registered read.
module z80_mem_bridge #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        wait_n,
    output logic [9:0]  mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RD_HOLD,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_din_nxt;
    logic [DW-1:0]   d_out_nxt;
    logic            mem_we_nxt;
    logic            d_oe_nxt;
    logic            wait_n_nxt;

    logic sel;
    logic rd_act;
    logic wr_act;

    assign sel    = !mreq_n && (a[15:10] == BASE_ADDR[15:10]);
    assign rd_act = !mreq_n && !rd_n;
    assign wr_act = !mreq_n && !wr_n;

    // State and all bus-facing outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            d_out    <= '0;
            d_oe     <= 1'b0;
            wait_n   <= 1'b1;
        end else begin
            state    <= state_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            mem_we   <= mem_we_nxt;
            d_out    <= d_out_nxt;
            d_oe     <= d_oe_nxt;
            wait_n   <= wait_n_nxt;
        end
    end

    // Next-state and next-output logic; mem_we defaults low so it can only ever pulse.
    always_comb begin
        state_nxt    = state;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        mem_we_nxt   = 1'b0;
        d_out_nxt    = d_out;
        d_oe_nxt     = d_oe;
        wait_n_nxt   = wait_n;

        case (state)
            IDLE: begin
                if (sel && !rd_n) begin
                    mem_addr_nxt = a[AW-1:0];
                    wait_n_nxt   = 1'b0;
                    state_nxt    = RD_ADDR;
                end else if (sel && !wr_n) begin
                    mem_addr_nxt = a[AW-1:0];
                    mem_din_nxt  = d_in;
                    mem_we_nxt   = 1'b1;
                    state_nxt    = WR_PULSE;
                end
            end
            RD_ADDR: begin
                if (!rd_act) begin
                    wait_n_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt  = RD_DATA;
                end
            end
            RD_DATA: begin
                if (!rd_act) begin
                    wait_n_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    d_out_nxt  = mem_dout;
                    d_oe_nxt   = 1'b1;
                    wait_n_nxt = 1'b1;
                    state_nxt  = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (!rd_act) begin
                    d_oe_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            WR_PULSE: begin
                // The RAM commits the write on this edge regardless of the strobes.
                state_nxt = WR_HOLD;
            end
            WR_HOLD: begin
                if (!wr_act) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                d_oe_nxt   = 1'b0;
                wait_n_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed bench for z80_mem_bridge: two instances (window at 0x0000 and 0x0400) share one bus,
// each with its own registered-read RAM model.
module tb_z80_mem_bridge;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic        mreq_n, rd_n, wr_n;

    logic [7:0]  d_out0, d_out1;
    logic        d_oe0, d_oe1;
    logic        wait_n0, wait_n1;
    logic [9:0]  mem_addr0, mem_addr1;
    logic [7:0]  mem_din0, mem_din1;
    logic        mem_we0, mem_we1;
    logic [7:0]  mem_dout0, mem_dout1;

    logic [7:0]  ram0 [0:1023];
    logic [7:0]  ram1 [0:1023];

    int total;
    int bad;
    int pulses;

    z80_mem_bridge #(.BASE_ADDR(16'h0000)) u0 (
        .clk(clk), .rst(rst), .a(a), .d_in(d_in), .d_out(d_out0), .d_oe(d_oe0),
        .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n0),
        .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_we(mem_we0), .mem_dout(mem_dout0)
    );

    z80_mem_bridge #(.BASE_ADDR(16'h0400)) u1 (
        .clk(clk), .rst(rst), .a(a), .d_in(d_in), .d_out(d_out1), .d_oe(d_oe1),
        .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n1),
        .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_we(mem_we1), .mem_dout(mem_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: write on edge with we high, read data registered one edge after the address.
    always_ff @(posedge clk) begin
        if (mem_we0) ram0[mem_addr0] <= mem_din0;
        mem_dout0 <= ram0[mem_addr0];
        if (mem_we1) ram1[mem_addr1] <= mem_din1;
        mem_dout1 <= ram1[mem_addr1];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pulses = 0;
        rst    = 1'b1;
        a      = 16'h0000;
        d_in   = 8'h00;
        bus_idle();
        #12;
        chk("rst_wait_n",   16'(wait_n0),   16'h1);
        chk("rst_mem_we",   16'(mem_we0),   16'h0);
        chk("rst_d_oe",     16'(d_oe0),     16'h0);
        chk("rst_d_out",    16'(d_out0),    16'h0);
        chk("rst_mem_addr", 16'(mem_addr0), 16'h0);
        chk("rst_mem_din",  16'(mem_din0),  16'h0);
        rst = 1'b0;
        step();

        // Write A5 to 0x0123
        a = 16'h0123; d_in = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
        step();
        chk("wr_we_e0",    16'(mem_we0),   16'h1);
        chk("wr_addr",     16'(mem_addr0), 16'h123);
        chk("wr_din",      16'(mem_din0),  16'hA5);
        chk("wr_wait_n",   16'(wait_n0),   16'h1);
        chk("wr_u1_we",    16'(mem_we1),   16'h0);
        step();
        chk("wr_we_e1",    16'(mem_we0),   16'h0);
        chk("wr_wait_n1",  16'(wait_n0),   16'h1);
        bus_idle();
        step();
        step();

        // Read back 0x0123
        a = 16'h0123; mreq_n = 1'b0; rd_n = 1'b0;
        step();
        chk("rd_wait_e0",  16'(wait_n0), 16'h0);
        chk("rd_oe_e0",    16'(d_oe0),   16'h0);
        chk("rd_u1_wait",  16'(wait_n1), 16'h1);
        step();
        chk("rd_wait_e1",  16'(wait_n0), 16'h0);
        step();
        chk("rd_wait_e2",  16'(wait_n0), 16'h1);
        chk("rd_oe_e2",    16'(d_oe0),   16'h1);
        chk("rd_dout_e2",  16'(d_out0),  16'hA5);
        step();
        chk("rd_oe_hold",  16'(d_oe0),   16'h1);
        chk("rd_dout_hold",16'(d_out0),  16'hA5);
        bus_idle();
        step();
        chk("rd_oe_rel",   16'(d_oe0),   16'h0);
        chk("rd_dout_rel", 16'(d_out0),  16'hA5);
        step();

        // 0x0400: outside u0's window, inside u1's
        a = 16'h0400; d_in = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
        step();
        chk("oow_u0_we",   16'(mem_we0),   16'h0);
        chk("oow_u0_wait", 16'(wait_n0),   16'h1);
        chk("win_u1_we",   16'(mem_we1),   16'h1);
        chk("win_u1_addr", 16'(mem_addr1), 16'h000);
        chk("win_u1_din",  16'(mem_din1),  16'h5A);
        step();
        bus_idle();
        step();
        step();
        a = 16'h0400; mreq_n = 1'b0; rd_n = 1'b0;
        step();
        chk("oow_u0_rwait", 16'(wait_n0), 16'h1);
        chk("win_u1_rwait", 16'(wait_n1), 16'h0);
        step();
        step();
        chk("oow_u0_oe",   16'(d_oe0),  16'h0);
        chk("win_u1_oe",   16'(d_oe1),  16'h1);
        chk("win_u1_dout", 16'(d_out1), 16'h5A);
        bus_idle();
        step();
        chk("win_u1_oe_rel", 16'(d_oe1), 16'h0);
        step();

        // Abort in RD_ADDR
        a = 16'h0123; mreq_n = 1'b0; rd_n = 1'b0;
        step();
        chk("ab_wait_e0", 16'(wait_n0), 16'h0);
        mreq_n = 1'b1;
        step();
        chk("ab_wait_e1", 16'(wait_n0), 16'h1);
        chk("ab_oe_e1",   16'(d_oe0),   16'h0);
        rd_n = 1'b1;
        step();
        chk("ab_oe_e2",   16'(d_oe0),   16'h0);
        // Back in IDLE: a fresh write is accepted at once
        a = 16'h0010; d_in = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
        step();
        chk("ab_idle_we", 16'(mem_we0), 16'h1);
        step();
        bus_idle();
        step();
        step();

        // Async reset in RD_DATA (d_out still holds A5 from before)
        a = 16'h0123; mreq_n = 1'b0; rd_n = 1'b0;
        step();
        step();
        chk("rr_wait_pre", 16'(wait_n0), 16'h0);
        rst = 1'b1;
        #1;
        chk("rr_wait",  16'(wait_n0), 16'h1);
        chk("rr_oe",    16'(d_oe0),   16'h0);
        chk("rr_dout",  16'(d_out0),  16'h0);
        bus_idle();
        #2;
        rst = 1'b0;
        step();
        a = 16'h0001; d_in = 8'h3C; mreq_n = 1'b0; wr_n = 1'b0;
        step();
        chk("rr_wr_we", 16'(mem_we0), 16'h1);
        step();
        bus_idle();
        step();
        step();
        a = 16'h0001; mreq_n = 1'b0; rd_n = 1'b0;
        step();
        step();
        step();
        chk("rr_rd_oe",   16'(d_oe0),  16'h1);
        chk("rr_rd_dout", 16'(d_out0), 16'h3C);
        bus_idle();
        step();
        step();

        // rd_n and wr_n low together: read wins, no write pulse
        a = 16'h0010; d_in = 8'hEE; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_we0) pulses++;
        end
        chk("both_we_cnt", 16'(pulses),  16'h0);
        chk("both_oe",     16'(d_oe0),   16'h1);
        chk("both_dout",   16'(d_out0),  16'h77);
        bus_idle();
        step();
        step();

        // One long write strobe yields exactly one pulse
        a = 16'h0200; d_in = 8'hC3; mreq_n = 1'b0; wr_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_we0) pulses++;
            chk("long_wait_n", 16'(wait_n0), 16'h1);
        end
        chk("long_we_cnt", 16'(pulses),   16'h1);
        chk("long_din",    16'(mem_din0), 16'hC3);
        bus_idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
